// File: rtl/drone_esc_pwm_multi.sv
// Multi-channel ESC/servo PWM generator: shared timebase, frame-aligned double-buffered commands, arming and command-timeout failsafe.
// Optional build macro DRONE_PWM_STAGGER_EN spreads each channel's frame phase evenly across the frame.
module drone_esc_pwm_multi #(
  parameter int unsigned CH             = 4,
  parameter int unsigned W              = 8,
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned FRAME_MS       = 20,
  parameter int unsigned TIMEOUT_FRAMES = 5
) (
  input  logic            clk,
  input  logic            reset_p,
  input  logic            arm,
  input  logic            cmd_we,
  input  logic [CH*W-1:0] cmd_data,
  output logic [CH-1:0]   pwm,
  output logic            frame_start,
  output logic            failsafe,
  output logic            armed
);

  localparam int unsigned TICK_DIV    = CLK_HZ / (1000 * (2 ** W));
  localparam int unsigned FRAME_TICKS = FRAME_MS * (2 ** W);
  localparam int unsigned TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW          = $clog2(FRAME_TICKS);
  localparam int unsigned PW          = FW + 1;
  localparam int unsigned WDW         = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

  logic [TW-1:0]  tcnt;
  logic [FW-1:0]  fcnt;
  logic [W-1:0]   pending [CH];
  logic [W-1:0]   act     [CH];
  logic [WDW-1:0] wdog;

  logic           tick;
  logic           boundary;
  logic           fs_next;
  logic [WDW-1:0] wdog_next;
  logic [FW-1:0]  phase   [CH];
  logic [CH-1:0]  load;

  always_comb begin
    tick     = (tcnt == TW'(TICK_DIV - 1));
    boundary = tick && (fcnt == FW'(FRAME_TICKS - 1));
  end

  // Watchdog: boundaries since last cmd_we; a strobe always wins over a timeout.
  always_comb begin
    wdog_next = wdog;
    fs_next   = failsafe;
    if (cmd_we) begin
      wdog_next = '0;
      fs_next   = 1'b0;
    end else if (boundary && (TIMEOUT_FRAMES != 0)) begin
      if (wdog != WDW'(TIMEOUT_FRAMES))
        wdog_next = wdog + WDW'(1);
      if (wdog_next == WDW'(TIMEOUT_FRAMES))
        fs_next = 1'b1;
    end
  end

  // Per-channel frame phase; aligned to fcnt unless staggering is built in.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
`ifdef DRONE_PWM_STAGGER_EN
      logic [PW-1:0] sum;
      sum = PW'(fcnt) + PW'(i * (FRAME_TICKS / CH));
      if (sum >= PW'(FRAME_TICKS))
        phase[i] = FW'(sum - PW'(FRAME_TICKS));
      else
        phase[i] = FW'(sum);
`else
      phase[i] = fcnt;
`endif
      load[i] = tick && (phase[i] == FW'(FRAME_TICKS - 1));
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      tcnt        <= '0;
      fcnt        <= '0;
      wdog        <= '0;
      failsafe    <= 1'b1;
      armed       <= 1'b0;
      frame_start <= 1'b0;
      pwm         <= '0;
      for (int i = 0; i < CH; i++) begin
        pending[i] <= '0;
        act[i]     <= '0;
      end
    end else begin
      tcnt <= tick ? '0 : tcnt + TW'(1);
      if (tick)
        fcnt <= (fcnt == FW'(FRAME_TICKS - 1)) ? '0 : fcnt + FW'(1);
      frame_start <= boundary;
      wdog        <= wdog_next;
      failsafe    <= fs_next;
      if (boundary)
        armed <= arm;
      for (int i = 0; i < CH; i++) begin
        if (cmd_we)
          pending[i] <= cmd_data[i*W +: W];
        // Double-buffer swap; a strobe on the load edge bypasses pending.
        if (load[i]) begin
          if (arm && !fs_next)
            act[i] <= cmd_we ? cmd_data[i*W +: W] : pending[i];
          else
            act[i] <= '0;
        end
        pwm[i] <= (phase[i] < FW'({1'b1, act[i]}));
      end
    end
  end

endmodule
